// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared bus widths, field indices and divider states for the EXE stage
package exe_stage_pkg;

    localparam int ID_TO_EXE_BUS_WIDTH  = 151;
    localparam int EXE_TO_MEM_BUS_WIDTH = 71;
    localparam int BYPASS_BUS_WIDTH     = 38;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam int DIV_SIGNED_BIT = 0;
    localparam int DIV_MOD_BIT    = 1;
    localparam int DIV_EN_BIT     = 2;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [2:0]  div_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rkd_value;
        logic        mem_we;
        logic        res_from_mem;
        logic        reg_we;
        logic [4:0]  reg_waddr;
    } id_to_exe_t;

endpackage

// File: rtl/exe_divider.sv
// rtl/exe_divider.sv - 32-step restoring divider with sign correction and ack handshake
module exe_divider
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dsr_q, dsr_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dzero_q, dzero_d;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dzero_d = dzero_q;
        // quo_q doubles as the dividend shift register feeding rem_sh
        rem_sh  = {rem_q, quo_q[31]};
        rem_sub = rem_sh - {1'b0, dsr_q};
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = (is_signed && dividend[31]) ? -dividend : dividend;
                    dsr_d   = (is_signed && divisor[31]) ? -divisor : divisor;
                    q_neg_d = is_signed && (dividend[31] ^ divisor[31]);
                    r_neg_d = is_signed && dividend[31];
                    dzero_d = (divisor == 32'd0);
                    cnt_d   = '0;
                    state_d = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (!rem_sub[32]) begin
                    rem_d = rem_sub[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (ack) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dsr_q   <= dsr_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
        dzero_q <= dzero_d;
    end

    // divide-by-zero keeps the all-ones quotient regardless of operand signs
    assign done      = (state_q == DIV_DONE);
    assign quotient  = dzero_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_q : quo_q);
    assign remainder = r_neg_q ? -rem_q : rem_q;

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - EXE pipeline stage: ALU, optional divider (EXE_DIV_EN), data SRAM request
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    output logic                            exe_allow_in,
    input  logic                            id_to_exe_valid,
    input  logic                            mem_allow_in,
    output logic                            exe_to_mem_valid,
    input  logic [ID_TO_EXE_BUS_WIDTH-1:0]  id_to_exe_bus,
    output logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
    output logic                            exe_valid,
    output logic [BYPASS_BUS_WIDTH-1:0]     exe_to_id_bypass_bus,
    output logic                            exe_fwd_stall,
    output logic                            data_sram_en,
    output logic [3:0]                      data_sram_we,
    output logic [31:0]                     data_sram_addr,
    output logic [31:0]                     data_sram_wdata
);

    id_to_exe_t  bus_q, bus_d;
    logic        exe_valid_q, exe_valid_d;
    logic        exe_ready_go;
    logic        fire;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic [4:0]  sh;

    always_comb begin
        exe_valid_d = exe_valid_q;
        bus_d       = bus_q;
        if (exe_allow_in) begin
            exe_valid_d = id_to_exe_valid;
        end
        if (exe_allow_in && id_to_exe_valid) begin
            bus_d = id_to_exe_t'(id_to_exe_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            exe_valid_q <= 1'b0;
        end else begin
            exe_valid_q <= exe_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        bus_q <= bus_d;
    end

    assign sh = bus_q.src2[4:0];

    always_comb begin
        alu_result = '0;
        if (bus_q.alu_op[ALU_ADD])  alu_result |= bus_q.src1 + bus_q.src2;
        if (bus_q.alu_op[ALU_SUB])  alu_result |= bus_q.src1 - bus_q.src2;
        if (bus_q.alu_op[ALU_SLT])  alu_result |= {31'b0, $signed(bus_q.src1) < $signed(bus_q.src2)};
        if (bus_q.alu_op[ALU_SLTU]) alu_result |= {31'b0, bus_q.src1 < bus_q.src2};
        if (bus_q.alu_op[ALU_AND])  alu_result |= bus_q.src1 & bus_q.src2;
        if (bus_q.alu_op[ALU_NOR])  alu_result |= ~(bus_q.src1 | bus_q.src2);
        if (bus_q.alu_op[ALU_OR])   alu_result |= bus_q.src1 | bus_q.src2;
        if (bus_q.alu_op[ALU_XOR])  alu_result |= bus_q.src1 ^ bus_q.src2;
        if (bus_q.alu_op[ALU_SLL])  alu_result |= bus_q.src1 << sh;
        if (bus_q.alu_op[ALU_SRL])  alu_result |= bus_q.src1 >> sh;
        if (bus_q.alu_op[ALU_SRA])  alu_result |= 32'($signed(bus_q.src1) >>> sh);
        if (bus_q.alu_op[ALU_LUI])  alu_result |= bus_q.src2;
    end

`ifdef EXE_DIV_EN
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    exe_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (exe_valid_q && bus_q.div_op[DIV_EN_BIT]),
        .is_signed (bus_q.div_op[DIV_SIGNED_BIT]),
        .dividend  (bus_q.src1),
        .divisor   (bus_q.src2),
        .ack       (fire),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign exe_ready_go = !bus_q.div_op[DIV_EN_BIT] || div_done;
    assign result       = bus_q.div_op[DIV_EN_BIT] ?
                          (bus_q.div_op[DIV_MOD_BIT] ? div_rem : div_quo) : alu_result;
`else
    logic unused_div_op;

    // divides are trapped in ID when the divider is absent
    assign unused_div_op = ^bus_q.div_op;
    assign exe_ready_go  = 1'b1;
    assign result        = alu_result;
`endif

    assign exe_valid        = exe_valid_q;
    assign exe_allow_in     = !exe_valid_q || (exe_ready_go && mem_allow_in);
    assign exe_to_mem_valid = exe_valid_q && exe_ready_go;
    assign fire             = exe_valid_q && exe_ready_go && mem_allow_in;

    assign exe_to_mem_bus       = {bus_q.pc, result, bus_q.res_from_mem, bus_q.reg_we, bus_q.reg_waddr};
    assign exe_to_id_bypass_bus = {bus_q.reg_we, bus_q.reg_waddr, result};
    assign exe_fwd_stall        = exe_valid_q && bus_q.reg_we && (bus_q.res_from_mem || !exe_ready_go);

    // request only in the hand-off cycle so a stalled access is never repeated
    assign data_sram_en    = fire && (bus_q.res_from_mem || bus_q.mem_we);
    assign data_sram_we    = (fire && bus_q.mem_we) ? 4'hf : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = bus_q.rkd_value;

endmodule
